// File: rtl/xadac_axi_mem_if.sv
// AXI single-beat channel subset between the xadac accelerator (master) and
// its simulation memory (slave).
interface xadac_axi_mem_if #(
   parameter int IdWidth   = 4,
   parameter int AddrWidth = 64,
   parameter int DataWidth = 128
);
   // Every channel transfers on a rising edge where valid && ready; the
   // sender keeps its payload stable and valid high until that edge.
   logic [IdWidth-1:0]     aw_id;
   logic [AddrWidth-1:0]   aw_addr;
   logic                   aw_valid;
   logic                   aw_ready;
   logic [DataWidth-1:0]   w_data;
   logic [DataWidth/8-1:0] w_strb;
   logic                   w_valid;
   logic                   w_ready;
   logic [IdWidth-1:0]     b_id;
   logic                   b_valid;
   logic                   b_ready;
   logic [IdWidth-1:0]     ar_id;
   logic [AddrWidth-1:0]   ar_addr;
   logic                   ar_valid;
   logic                   ar_ready;
   logic [IdWidth-1:0]     r_id;
   logic [DataWidth-1:0]   r_data;
   logic                   r_valid;
   logic                   r_ready;

   modport master (
      output aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_id, ar_addr, ar_valid, r_ready,
      input  aw_ready, w_ready, b_id, b_valid, ar_ready, r_id, r_data, r_valid
   );

   modport slave (
      input  aw_id, aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_id, ar_addr, ar_valid, r_ready,
      output aw_ready, w_ready, b_id, b_valid, ar_ready, r_id, r_data, r_valid
   );
endinterface

// File: rtl/xadac_axi_mem.sv
// Word-addressed AXI memory responder closing the xadac memory loop in
// simulation: one outstanding write and one outstanding read, independent.
module xadac_axi_mem #(
   parameter int IdWidth     = 4,
   parameter int AddrWidth   = 64,
   parameter int DataWidth   = 128,
   parameter int Depth       = 1024,
   parameter int ReadLatency = 2
) (
   input  logic             clk,
   input  logic             rst,
   xadac_axi_mem_if.slave   axi,
   output logic [1:0]       rd_state
);
   localparam int NumBytes = DataWidth / 8;
   localparam int OffBits  = $clog2(NumBytes);
   localparam int IdxBits  = $clog2(Depth);
   localparam logic [3:0] Latency = 4'(ReadLatency);

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_RESP = 2'd2
   } r_state_e;

   // Contents survive reset; only time zero clears them.
   logic [DataWidth-1:0] mem [Depth] = '{default: '0};

   logic [IdxBits-1:0] aw_idx;
   logic [IdxBits-1:0] ar_idx;
   logic               unused_addr_bits;

   assign aw_idx = axi.aw_addr[OffBits +: IdxBits];
   assign ar_idx = axi.ar_addr[OffBits +: IdxBits];
   assign unused_addr_bits = ^{axi.aw_addr, axi.ar_addr};

   // ---------------- write path ----------------
   logic                 aw_held;
   logic [IdWidth-1:0]   aw_id_q;
   logic [IdxBits-1:0]   aw_idx_q;
   logic                 w_held;
   logic [DataWidth-1:0] w_data_q;
   logic [NumBytes-1:0]  w_strb_q;
   logic                 commit;

   assign axi.aw_ready = !rst && !aw_held;
   assign axi.w_ready  = !rst && !w_held;
   assign commit       = !rst && aw_held && w_held && !axi.b_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held     <= 1'b0;
         w_held      <= 1'b0;
         aw_id_q     <= '0;
         aw_idx_q    <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         axi.b_valid <= 1'b0;
         axi.b_id    <= '0;
      end else begin
         if (axi.b_valid && axi.b_ready) begin
            axi.b_valid <= 1'b0;
         end
         // Commit needs both held flags, so it never overlaps a new accept.
         if (commit) begin
            axi.b_valid <= 1'b1;
            axi.b_id    <= aw_id_q;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
         end
         if (axi.aw_valid && axi.aw_ready) begin
            aw_held  <= 1'b1;
            aw_id_q  <= axi.aw_id;
            aw_idx_q <= aw_idx;
         end
         if (axi.w_valid && axi.w_ready) begin
            w_held   <= 1'b1;
            w_data_q <= axi.w_data;
            w_strb_q <= axi.w_strb;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (w_strb_q[b]) begin
               mem[aw_idx_q][b*8 +: 8] <= w_data_q[b*8 +: 8];
            end
         end
      end
   end

   // ---------------- read path ----------------
   r_state_e           state;
   r_state_e           state_nx;
   logic [3:0]         cnt;
   logic [IdxBits-1:0] rd_idx;
   logic               ar_fire;

   assign axi.ar_ready = !rst && (state == R_IDLE);
   assign axi.r_valid  = (state == R_RESP);
   assign ar_fire      = axi.ar_valid && axi.ar_ready;
   assign rd_state     = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= R_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         R_IDLE: begin
            if (ar_fire) begin
               state_nx = (Latency == 4'd0) ? R_RESP : R_WAIT;
            end
         end
         R_WAIT: begin
            if (cnt == 4'd1) begin
               state_nx = R_RESP;
            end
         end
         R_RESP: begin
            if (axi.r_ready) begin
               state_nx = R_IDLE;
            end
         end
         default: state_nx = R_IDLE;
      endcase
   end

   // Nonblocking reads of mem see the pre-commit word on a shared edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         rd_idx     <= '0;
         axi.r_id   <= '0;
         axi.r_data <= '0;
      end else begin
         case (state)
            R_IDLE: begin
               if (ar_fire) begin
                  axi.r_id <= axi.ar_id;
                  rd_idx   <= ar_idx;
                  cnt      <= Latency;
                  if (Latency == 4'd0) begin
                     axi.r_data <= mem[ar_idx];
                  end
               end
            end
            R_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  axi.r_data <= mem[rd_idx];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_xadac_axi_mem.sv
// Directed bench for xadac_axi_mem: write/read latency, strobes, B stall,
// address wrap, read-before-write collision and mid-transaction reset.
module tb_xadac_axi_mem;
   localparam int IW    = 4;
   localparam int AW    = 64;
   localparam int DW    = 128;
   localparam int DEPTH = 1024;
   localparam int RL    = 2;

   localparam logic [DW-1:0]   D1   = 128'h0123_4567_89ab_cdef_fedc_ba98_0011_2233;
   localparam logic [DW-1:0]   W3   = {4{32'hDEAD_BEEF}};
   localparam logic [DW-1:0]   W3_E = 128'h0000_0000_0000_0000_DEAD_BEEF_0000_0000;
   localparam logic [DW-1:0]   W9   = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
   localparam logic [DW-1:0]   D4   = 128'hcafe_f00d_0bad_beef_1234_5678_9abc_def0;
   localparam logic [DW-1:0]   D5   = 128'h5555_aaaa_5555_aaaa_5555_aaaa_5555_aaaa;
   localparam logic [DW/8-1:0] ALL  = '1;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] rd_state;

   always #5 clk = ~clk;

   xadac_axi_mem_if #(.IdWidth(IW), .AddrWidth(AW), .DataWidth(DW)) axi ();

   xadac_axi_mem #(
      .IdWidth(IW), .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .ReadLatency(RL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .axi(axi),
      .rd_state(rd_state)
   );

   // ---------------- scoreboard ----------------
   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pair(input string tag, input logic [IW-1:0] id,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [DW/8-1:0] strb);
      int n;
      axi.aw_id    = id;
      axi.aw_addr  = addr;
      axi.aw_valid = 1'b1;
      axi.w_data   = data;
      axi.w_strb   = strb;
      axi.w_valid  = 1'b1;
      check($sformatf("%s_wr_rdy", tag), {126'd0, axi.aw_ready, axi.w_ready}, 128'd3);
      tick();
      axi.aw_valid = 1'b0;
      axi.w_valid  = 1'b0;
      n = 0;
      while (!axi.b_valid && n < 20) begin
         tick();
         n++;
      end
      check($sformatf("%s_b_lat", tag), DW'(n + 1), 128'd2);
      check($sformatf("%s_b_id", tag), DW'(axi.b_id), DW'(id));
      tick();
   endtask

   task automatic read_word(input string tag, input logic [IW-1:0] id,
                            input logic [AW-1:0] addr, input logic [DW-1:0] exp);
      int n;
      exp_q.push_back(exp);
      axi.ar_id    = id;
      axi.ar_addr  = addr;
      axi.ar_valid = 1'b1;
      check($sformatf("%s_ar_rdy", tag), DW'(axi.ar_ready), 128'd1);
      tick();
      axi.ar_valid = 1'b0;
      n = 0;
      while (!axi.r_valid && n < 40) begin
         tick();
         n++;
      end
      check($sformatf("%s_r_lat", tag), DW'(n + 1), DW'(RL + 1));
      check($sformatf("%s_r_id", tag), DW'(axi.r_id), DW'(id));
      check($sformatf("%s_r_data", tag), axi.r_data, exp_q.pop_front());
      tick();
      check($sformatf("%s_ar_back", tag), DW'(axi.ar_ready), 128'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      rst          = 1'b1;
      axi.aw_id    = '0;
      axi.aw_addr  = '0;
      axi.aw_valid = 1'b0;
      axi.w_data   = '0;
      axi.w_strb   = '0;
      axi.w_valid  = 1'b0;
      axi.b_ready  = 1'b1;
      axi.ar_id    = '0;
      axi.ar_addr  = '0;
      axi.ar_valid = 1'b0;
      axi.r_ready  = 1'b1;
      tick();
      tick();
      check("rst_readies", {125'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 128'd0);
      check("rst_valids", {126'd0, axi.b_valid, axi.r_valid}, 128'd0);
      check("rst_ids", {120'd0, axi.b_id, axi.r_id}, 128'd0);
      check("rst_r_data", axi.r_data, 128'd0);
      check("rst_state", DW'(rd_state), 128'd0);
      rst = 1'b0;
      #1;
      check("post_rst_readies", {125'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 128'd7);

      read_word("zero_init", 4'd1, 64'h200, 128'd0);

      write_pair("basic", 4'd5, 64'h40, D1, ALL);
      read_word("basic", 4'd6, 64'h40, D1);

      write_pair("pstrb", 4'd2, 64'h80, '1, 16'h0001);
      read_word("pstrb", 4'd2, 64'h80, 128'hFF);

      // W three cycles ahead of AW, B held off while a second pair arrives
      axi.b_ready = 1'b0;
      axi.w_data  = W3;
      axi.w_strb  = 16'h00F0;
      axi.w_valid = 1'b1;
      tick();
      axi.w_valid = 1'b0;
      check("stall_w_held", DW'(axi.w_ready), 128'd0);
      tick();
      tick();
      axi.aw_id    = 4'd3;
      axi.aw_addr  = 64'hC0;
      axi.aw_valid = 1'b1;
      tick();
      axi.aw_valid = 1'b0;
      check("stall_b_early", DW'(axi.b_valid), 128'd0);
      tick();
      check("stall_b_valid", DW'(axi.b_valid), 128'd1);
      check("stall_b_id", DW'(axi.b_id), 128'd3);
      axi.aw_id    = 4'd9;
      axi.aw_addr  = 64'h100;
      axi.aw_valid = 1'b1;
      axi.w_data   = W9;
      axi.w_strb   = ALL;
      axi.w_valid  = 1'b1;
      check("stall_accept2", {126'd0, axi.aw_ready, axi.w_ready}, 128'd3);
      tick();
      axi.aw_valid = 1'b0;
      axi.w_valid  = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("stall_b_hold", {123'd0, axi.b_valid, axi.b_id}, {123'd0, 1'b1, 4'd3});
      check("stall_2nd_held", {126'd0, axi.aw_ready, axi.w_ready}, 128'd0);
      axi.b_ready = 1'b1;
      tick();
      check("stall_b_drop", DW'(axi.b_valid), 128'd0);
      tick();
      check("stall_b2", {123'd0, axi.b_valid, axi.b_id}, {123'd0, 1'b1, 4'd9});
      tick();
      check("stall_b2_done", DW'(axi.b_valid), 128'd0);
      read_word("stall_w1", 4'd3, 64'hC0, W3_E);
      read_word("stall_w2", 4'd9, 64'h100, W9);

      write_pair("wrap", 4'd1, 64'h4000, D4, ALL);
      read_word("wrap_w0", 4'd4, 64'h0, D4);
      read_word("unaligned", 4'd7, 64'h47, D1);

      // Read sample and write commit land on the same edge for word 16
      axi.ar_id    = 4'd2;
      axi.ar_addr  = 64'h100;
      axi.ar_valid = 1'b1;
      exp_q.push_back(W9);
      check("coll_ar_rdy", DW'(axi.ar_ready), 128'd1);
      tick();
      axi.ar_valid = 1'b0;
      axi.aw_id    = 4'd4;
      axi.aw_addr  = 64'h100;
      axi.aw_valid = 1'b1;
      axi.w_data   = D5;
      axi.w_strb   = ALL;
      axi.w_valid  = 1'b1;
      check("coll_wr_rdy", {126'd0, axi.aw_ready, axi.w_ready}, 128'd3);
      tick();
      axi.aw_valid = 1'b0;
      axi.w_valid  = 1'b0;
      check("coll_pending", {126'd0, axi.b_valid, axi.r_valid}, 128'd0);
      tick();
      check("coll_both", {126'd0, axi.b_valid, axi.r_valid}, 128'd3);
      check("coll_old_data", axi.r_data, exp_q.pop_front());
      check("coll_ids", {120'd0, axi.b_id, axi.r_id}, {120'd0, 4'd4, 4'd2});
      tick();
      read_word("coll_new", 4'd8, 64'h100, D5);

      // Reset with a read in R_WAIT and a lone AW held
      axi.ar_id    = 4'd6;
      axi.ar_addr  = 64'h0;
      axi.ar_valid = 1'b1;
      tick();
      axi.ar_valid = 1'b0;
      axi.aw_id    = 4'd7;
      axi.aw_addr  = 64'h0;
      axi.aw_valid = 1'b1;
      tick();
      axi.aw_valid = 1'b0;
      check("mid_in_wait", DW'(rd_state), 128'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_readies", {125'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 128'd0);
      tick();
      check("mid_rst_valids", {126'd0, axi.b_valid, axi.r_valid}, 128'd0);
      check("mid_rst_r", {120'd0, axi.r_id, axi.r_data[3:0]}, 128'd0);
      tick();
      check("mid_rst_valids2", {126'd0, axi.b_valid, axi.r_valid}, 128'd0);
      rst = 1'b0;
      #1;
      check("mid_readies_back", {125'd0, axi.aw_ready, axi.w_ready, axi.ar_ready}, 128'd7);
      for (int i = 0; i < 3; i++) tick();
      check("mid_no_phantom", {126'd0, axi.b_valid, axi.r_valid}, 128'd0);
      read_word("mid_mem_kept", 4'd5, 64'h0, D4);

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/xadac_axi_mem.md
# xadac_axi_mem

Single-port AXI memory responder for simulation benches. It answers the AXI master port of the xadac accelerator. It accepts single-beat write (AW/W/B) and read (AR/R) transactions on the flattened id/addr/data/strb channel subset that the accelerator drives, and holds a word-addressed backing store. It sits on the Verilator top level, next to the xadac instance, and closes its memory loop.

## Interface

Parameters:
- IdWidth, default 4: AXI id width; must match the xadac IdWidth.
- AddrWidth, default 64: byte address width.
- DataWidth, default 128: beat width in bits; must match VecDataWidth and be a power of two ≥ 8.
- Depth, default 1024: number of DataWidth-bit words; power of two.
- ReadLatency, default 2: extra wait cycles before read data is presented; range 0–15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- aw_id  in  IdWidth  write request id.
- aw_addr  in  AddrWidth  write byte address.
- aw_valid  in  1 / aw_ready  out  1  AW handshake.
- w_data  in  DataWidth  write data.
- w_strb  in  DataWidth/8  byte enables.
- w_valid  in  1 / w_ready  out  1  W handshake.
- b_id  out  IdWidth  id of the completed write.
- b_valid  out  1 / b_ready  in  1  B handshake.
- ar_id  in  IdWidth  read request id.
- ar_addr  in  AddrWidth  read byte address.
- ar_valid  in  1 / ar_ready  out  1  AR handshake.
- r_id  out  IdWidth  id of the returned read.
- r_data  out  DataWidth  read data.
- r_valid  out  1 / r_ready  in  1  R handshake.

## Operation

- Word index = ar/aw_addr >> log2(DataWidth/8), truncated to log2(Depth) bits.
  - Low byte-offset bits are ignored.
  - Out-of-range addresses wrap modulo Depth.
- Memory is zero-initialised at time zero. Reset does not clear it.
- Write path:
  - Holding registers aw_q (id, index, held flag) and w_q (data, strb, held flag).
  - aw_ready = !rst && !aw_held. w_ready = !rst && !w_held.
  - AW and W are accepted independently, in either order or in the same cycle.
  - Commit when aw_held && w_held && !b_valid:
    - write the bytes with strb=1 into mem[index]; other bytes are unchanged;
    - b_valid←1, b_id←aw id;
    - clear both held flags.
  - b_valid holds with a stable b_id until b_ready.
- Read path FSM:
  - R_IDLE: ar_ready=1 (when !rst). On AR handshake, capture id and index and load cnt←ReadLatency. Go to R_WAIT if ReadLatency>0, else go to R_RESP with r_data←mem[index].
  - R_WAIT: cnt decrements each cycle. At the edge where cnt==1: r_data←mem[index], go to R_RESP.
  - R_RESP: r_valid=1, r_id and r_data stable. On r_ready, go to R_IDLE.
- Only one outstanding read and one outstanding write. Read and write paths are fully independent.
- Same-edge collision (read samples the word a write commits): read returns the old data (read-before-write).
- Memory access is word-granular. The read path ignores strobes.

## Timing

- Reset (rst high at an edge):
  - b_valid=0, r_valid=0, b_id=0, r_id=0, r_data=0;
  - held flags cleared, FSM→R_IDLE, cnt=0;
  - aw_ready, w_ready and ar_ready are driven 0 while rst is high.
- Write latency: AW and W handshakes in cycle N → commit at the end of cycle N+1 → b_valid high in cycle N+2.
  - If W arrives later than AW, latency is counted from the later handshake.
- While b_valid is stalled, the next AW/W can be accepted into empty holding registers. The next commit waits until the B handshake completes.
- Read latency: AR handshake in cycle N → r_valid high in cycle N+1+ReadLatency.
- ar_ready is low from the cycle after the AR handshake until the cycle after the R handshake. Back-to-back read throughput = 1 per (ReadLatency+2) cycles.
- Reset mid-transaction: in-flight writes that have not committed are dropped, and a pending B or R is discarded. Memory keeps any committed data.

## Test plan

- DataWidth=128, write addr 0x40 data 0x…0011_2233 strb all-ones → b_valid 2 cycles after the handshakes, b_id=aw_id. Then read 0x40 → r_valid ReadLatency+1 cycles after AR, r_data matches, r_id=ar_id.
- Partial strobe: write 0xFF.. with strb=0x0001 to a zero word, then read it → only byte 0 = 0xFF, all other bytes 0.
- W before AW by 3 cycles, with b_ready held low for 5 cycles → single B with the correct id. A second AW/W pair is accepted during the stall and commits only after the first B handshake.
- Address wrap: Depth=1024, write to word 1024 (addr 0x4000), read word 0 → same data. Read addr 0x47 (unaligned) returns word 4.
- Same-edge collision: arrange a read sample and a write commit to the same word on the same edge → r_data = old value. A subsequent read returns the new value.
- Assert rst while in R_WAIT and with AW held → r_valid and b_valid stay 0, all readies low while rst=1, readies return to 1 the cycle after rst drops, and previously committed memory data is still readable.
